// File: rtl/wb_stage.sv
// Writeback stage: sole writer of the register-file write port. ALU results
// retire one cycle after acceptance; loads park in WAIT_LOAD until the data
// memory responds (or a timeout aborts them), then are aligned and extended.
module wb_stage #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk_I,
  input  logic             rst_n_I,
  input  logic             mem_valid_I,
  output logic             mem_ready_O,
  input  logic [4:0]       mem_rd_I,
  input  logic [31:0]      mem_result_I,
  input  logic             mem_is_load_I,
  input  logic [2:0]       mem_funct3_I,
  input  logic [1:0]       mem_addr_lo_I,
  input  logic             dmem_rsp_valid_I,
  input  logic [31:0]      dmem_rsp_data_I,
  output logic             w_en_O,
  output logic [4:0]       destReg_O,
  output logic [31:0]      destRegWrite_O,
  output logic             load_pending_O,
  output logic [4:0]       pending_rd_O,
  output logic [CNT_W-1:0] retired_O,
  output logic             err_O
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [0:0] {StIdle, StWaitLoad} state_e;

  state_e            state_q;
  logic [4:0]        ld_rd_q;
  logic [2:0]        ld_f3_q;
  logic [1:0]        ld_lo_q;
  logic [TW-1:0]     tmo_q;
  logic [TW-1:0]     tmo_inc;
  logic              w_en_q;
  logic [4:0]        dest_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  retired_q;
  logic              err_q;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;

  assign tmo_inc = tmo_q + TW'(1);

  // Select and extend the loaded byte/half/word per the captured load type
  always_comb begin
    ld_byte = dmem_rsp_data_I[7:0];
    unique case (ld_lo_q)
      2'd0: ld_byte = dmem_rsp_data_I[7:0];
      2'd1: ld_byte = dmem_rsp_data_I[15:8];
      2'd2: ld_byte = dmem_rsp_data_I[23:16];
      2'd3: ld_byte = dmem_rsp_data_I[31:24];
    endcase
    // addr_lo[0] is deliberately ignored for halfwords
    ld_half = ld_lo_q[1] ? dmem_rsp_data_I[31:16] : dmem_rsp_data_I[15:0];
    case (ld_f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rsp_data_I;  // LW and undefined encodings
    endcase
  end

  // Control FSM with registered write port, counters and sticky error
  always_ff @(posedge clk_I or negedge rst_n_I) begin
    if (!rst_n_I) begin
      state_q   <= StIdle;
      ld_rd_q   <= 5'd0;
      ld_f3_q   <= 3'd0;
      ld_lo_q   <= 2'd0;
      tmo_q     <= '0;
      w_en_q    <= 1'b0;
      dest_q    <= 5'd0;
      wdata_q   <= 32'd0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      w_en_q <= 1'b0;
      // A response with no load outstanding is a protocol error, even on accept
      if (dmem_rsp_valid_I && (state_q == StIdle)) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (mem_valid_I) begin
            if (mem_is_load_I) begin
              ld_rd_q <= mem_rd_I;
              ld_f3_q <= mem_funct3_I;
              ld_lo_q <= mem_addr_lo_I;
              tmo_q   <= '0;
              state_q <= StWaitLoad;
            end else begin
              w_en_q    <= (mem_rd_I != 5'd0);
              dest_q    <= mem_rd_I;
              wdata_q   <= mem_result_I;
              retired_q <= retired_q + CNT_W'(1);
            end
          end
        end
        StWaitLoad: begin
          // A response on the final allowed cycle still completes the load
          if (dmem_rsp_valid_I) begin
            w_en_q    <= (ld_rd_q != 5'd0);
            dest_q    <= ld_rd_q;
            wdata_q   <= ld_ext;
            retired_q <= retired_q + CNT_W'(1);
            ld_rd_q   <= 5'd0;
            state_q   <= StIdle;
          end else if (tmo_inc == TW'(TIMEOUT_CYC)) begin
            err_q   <= 1'b1;
            ld_rd_q <= 5'd0;
            tmo_q   <= '0;
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_ready_O    = (state_q == StIdle);
  assign load_pending_O = (state_q == StWaitLoad);
  assign pending_rd_O   = (state_q == StWaitLoad) ? ld_rd_q : 5'd0;
  assign w_en_O         = w_en_q;
  assign destReg_O      = dest_q;
  assign destRegWrite_O = wdata_q;
  assign retired_O      = retired_q;
  assign err_O          = err_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32I pipeline. It is the sole writer of the register file's write port (w_en/dest/data).
- Accepts retiring instructions from the MEM stage over a valid/ready handshake. ALU results pass through directly; loads wait for the data-memory response, then are aligned and extended.
- Drives the registered write port plus forwarding and load-hazard information for the decode/hazard logic.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT_CYC, 255, maximum cycles spent waiting for a load response before abort (must be ≥1).

Ports:
- clk_I  in  1  clock; all state updates on the rising edge.
- rst_n_I  in  1  asynchronous active-low reset.
- mem_valid_I  in  1  MEM stage presents an instruction.
- mem_ready_O  out  1  stage can accept; high iff state==IDLE.
- mem_rd_I  in  5  destination register.
- mem_result_I  in  32  ALU/JAL result (ignored for loads).
- mem_is_load_I  in  1  instruction is a load.
- mem_funct3_I  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_addr_lo_I  in  2  load byte address bits [1:0].
- dmem_rsp_valid_I  in  1  data-memory read data valid.
- dmem_rsp_data_I  in  32  word-aligned read data.
- w_en_O  out  1  regfile write enable.
- destReg_O  out  5  regfile write address.
- destRegWrite_O  out  32  regfile write data.
- load_pending_O  out  1  a load is waiting for its response.
- pending_rd_O  out  5  rd of the pending load; 0 when none is pending.
- retired_O  out  CNT_W  count of completed instructions.
- err_O  out  1  sticky error flag: load timeout or unsolicited response.

Behaviour:
- Reset (async, rst_n_I=0):
  - state=IDLE; w_en_O=0, destReg_O=0, destRegWrite_O=0.
  - load_pending_O=0, pending_rd_O=0, retired_O=0, err_O=0, timeout counter=0.
  - mem_ready_O=1.
  - Reset mid-load abandons the load with no write; a response arriving after reset counts as unsolicited.
- Accept condition: mem_valid_I & mem_ready_O.
- w_en_O is a one-cycle pulse. It defaults to 0 every cycle unless a write is issued that cycle.
- IDLE, non-load accepted:
  - The next cycle drives w_en_O=(mem_rd_I!=0), destReg_O=mem_rd_I, destRegWrite_O=mem_result_I.
  - Latency is 1 cycle; throughput is 1 per cycle.
  - retired_O increments in that cycle even when rd=0.
- IDLE, load accepted:
  - Capture rd, funct3 and addr_lo; go to WAIT_LOAD.
  - load_pending_O=1 and pending_rd_O=rd from the next cycle.
  - mem_ready_O=0 while in WAIT_LOAD.
- WAIT_LOAD, dmem_rsp_valid_I=1:
  - Extract and extend the data per the captured funct3.
  - Next cycle: w_en_O=(rd!=0), destReg_O=rd, destRegWrite_O=extended value, retired_O+1, state=IDLE, load_pending_O=0, pending_rd_O=0.
  - Minimum load occupancy is 2 cycles (accept, response) before ready returns.
- Load extraction:
  - LB/LBU: byte = data[8*addr_lo +: 8]; sign- or zero-extend to 32 bits.
  - LH/LHU: half = addr_lo[1] ? data[31:16] : data[15:0]; addr_lo[0] is ignored (misalignment is handled upstream).
  - LW: full word; addr_lo is ignored.
  - Undefined funct3 values (011, 110, 111) are treated as LW.
- Timeout:
  - The counter clears on load accept and increments each WAIT_LOAD cycle without a response.
  - When it reaches TIMEOUT_CYC: return to IDLE, issue no write, set err_O, leave retired_O unchanged.
  - A response in the same cycle the count reaches TIMEOUT_CYC wins: the load completes normally.
- dmem_rsp_valid_I while in IDLE is ignored for data and sets err_O. This also applies when it coincides with an accept.
- retired_O wraps modulo 2^CNT_W.
- err_O clears only on reset.

Test Plan:
- ALU stream: valid every cycle with rd=1,2,3 and results 0x11,0x22,0x33 -> ready stays 1; w_en_O pulses on three consecutive cycles, each one cycle after its accept, with matching data; retired_O=3.
- rd=0 ALU op with result 0xDEAD -> w_en_O stays 0; retired_O increments.
- LB, addr_lo=2, response 0x12_80_34_56 after 3 cycles -> ready=0 and pending_rd_O=rd while waiting; then write 0xFFFFFF80.
- Same response with LBU -> 0x00000080.
- LH, addr_lo=2, response 0x8001_7FFF -> 0xFFFF8001; LHU -> 0x00008001.
- Load with TIMEOUT_CYC=4 and no response -> after 4 wait cycles: state IDLE, no write, err_O=1.
- Unsolicited response in IDLE -> err_O=1.
- Reset asserted mid-load -> all outputs 0 immediately and ready=1.
